// File: rtl/if_stage.sv
// Instruction fetch stage: drives a request/ack memory port and presents one registered
// instruction to decode. A one-entry skid buffer absorbs a word acked while decode is frozen.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        freeze_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_out_o,
    output logic        valid_o
);

    // state  | meaning
    // S_IDLE | after reset, no request; moves to S_REQ on the next edge
    // S_REQ  | request driven at fetch_q until acked
    // S_HOLD | word parked in the skid buffer, waiting for freeze to drop
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] fetch_q, fetch_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] target_q, target_d;

    logic [31:0] br_aligned;
    logic [31:0] fetch_inc;
    logic        ack;

    assign br_aligned = {branch_addr_i[31:2], 2'b00};
    assign fetch_inc  = fetch_q + 32'd4;
    assign ack        = imem_ack_i && (state_q == S_REQ);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            fetch_q      <= RESET_PC_ALIGNED;
            instr_q      <= 32'h0;
            pc_q         <= 32'h0;
            valid_q      <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            discard_q    <= 1'b0;
            target_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_q      <= fetch_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            discard_q    <= discard_d;
            target_q     <= target_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_d      = fetch_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        discard_d    = discard_q;
        target_d     = target_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (branch_taken_i) begin
                    fetch_d = br_aligned;
                    valid_d = 1'b0;
                end
            end
            S_REQ: begin
                if (branch_taken_i) begin
                    valid_d    = 1'b0;
                    skid_vld_d = 1'b0;
                    if (ack) begin
                        fetch_d   = br_aligned;
                        discard_d = 1'b0;
                    end else begin
                        // address must stay put until the in-flight request is acked
                        discard_d = 1'b1;
                        target_d  = br_aligned;
                    end
                end else if (ack && discard_q) begin
                    discard_d = 1'b0;
                    fetch_d   = target_q;
                    if (!freeze_i) begin
                        valid_d = 1'b0;
                    end
                end else if (ack && !freeze_i) begin
                    instr_d = imem_rdata_i;
                    pc_d    = fetch_inc;
                    valid_d = 1'b1;
                    fetch_d = fetch_inc;
                end else if (ack) begin
                    skid_vld_d   = 1'b1;
                    skid_instr_d = imem_rdata_i;
                    skid_pc_d    = fetch_inc;
                    fetch_d      = fetch_inc;
                    state_d      = S_HOLD;
                end else if (!freeze_i) begin
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (branch_taken_i) begin
                    valid_d    = 1'b0;
                    skid_vld_d = 1'b0;
                    fetch_d    = br_aligned;
                    state_d    = S_REQ;
                end else if (!freeze_i) begin
                    instr_d    = skid_instr_q;
                    pc_d       = skid_pc_q;
                    valid_d    = skid_vld_q;
                    skid_vld_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = fetch_q;
    assign instruction_o = instr_q;
    assign pc_out_o      = pc_q;
    assign valid_o       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle table for the basic pipeline behaviour, a scoreboarded random
// run of latency/freeze, then hand sequences for branch, skid, wrap and reset corners.
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        br;
    logic [31:0] br_addr;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .freeze_i       (freeze),
        .branch_taken_i (br),
        .branch_addr_i  (br_addr),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_ack_i     (ack),
        .imem_rdata_i   (rdata),
        .instruction_o  (instr),
        .pc_out_o       (pc),
        .valid_o        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        frz;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    vec_t tbl[17];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic f, input logic b, input logic [31:0] ba);
        ack     = a;
        freeze  = f;
        br      = b;
        br_addr = ba;
        rdata   = addr ^ KEY;
        @(posedge clk);
        #1;
        ack = 1'b0;
        br  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_fetch;
        logic        f;
        logic        a;
        exp_t        e;

        rst_n = 1'b0; freeze = 1'b0; br = 1'b0; br_addr = 32'h0; ack = 1'b0; rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req",   {31'h0, req},   32'h0);
        chk("reset_addr",  addr,           32'h0);
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_pc",    pc,             32'h0);
        chk("reset_instr", instr,          32'h0);
        rst_n = 1'b1;

        //           ack  frz req addr       v  pc         instr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h04, KEY};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h08, KEY ^ 32'h04};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0C, KEY ^ 32'h08};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, KEY ^ 32'h0C};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h10, KEY ^ 32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h10, KEY ^ 32'h0C};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h14, KEY ^ 32'h10};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h18, KEY ^ 32'h14};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h1C, KEY ^ 32'h18};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h20, KEY ^ 32'h1C};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h24, 1'b1, 32'h20, KEY ^ 32'h1C};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h24, 1'b1, 32'h20, KEY ^ 32'h1C};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h24, 1'b1, 32'h20, KEY ^ 32'h1C};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h24, KEY ^ 32'h20};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b0, 32'h24, KEY ^ 32'h20};

        for (int i = 0; i < 17; i++) begin
            chk($sformatf("tbl%0d_req", i),   {31'h0, req},   {31'h0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_addr", i),  addr,           tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'h0, valid}, {31'h0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_pc", i),    pc,             tbl[i].exp_pc);
            chk($sformatf("tbl%0d_instr", i), instr,          tbl[i].exp_instr);
            cyc(tbl[i].ack, tbl[i].frz, 1'b0, 32'h0);
        end

        // random latency / freeze run against an in-order scoreboard
        exp_fetch = 32'h24;
        for (int c = 0; c < 400; c++) begin
            f = ($urandom_range(0, 3) == 0);
            a = req && ($urandom_range(0, 2) != 0);
            if (req) chk("sb_addr", addr, exp_fetch);
            if (a) begin
                sbq.push_back('{instr: exp_fetch ^ KEY, pc: exp_fetch + 32'd4});
                exp_fetch = exp_fetch + 32'd4;
            end
            cyc(a, f, 1'b0, 32'h0);
            if (!f && valid) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_valid", {31'h0, valid}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_instr", instr, e.instr);
                    chk("sb_pc", pc, e.pc);
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            if (valid) begin
                if (sbq.size() == 0) begin
                    chk("drain_unexpected_valid", {31'h0, valid}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("drain_instr", instr, e.instr);
                    chk("drain_pc", pc, e.pc);
                end
            end
        end
        chk("sb_empty", sbq.size(), 32'd0);

        // branch with ack, then branch while outstanding, then last-branch-wins
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("brA_addr0", addr, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h33);
        chk("brA_ack_addr", addr, 32'h30);
        chk("brA_ack_valid", {31'h0, valid}, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        chk("brB_hold_addr", addr, 32'h30);
        chk("brB_hold_req", {31'h0, req}, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("brB_hold_addr2", addr, 32'h30);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("brB_discard_valid", {31'h0, valid}, 32'h0);
        chk("brB_new_addr", addr, 32'h100);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("brB_valid", {31'h0, valid}, 32'h1);
        chk("brB_pc", pc, 32'h104);
        chk("brB_instr", instr, 32'h100 ^ KEY);
        cyc(1'b0, 1'b0, 1'b1, 32'h300);
        cyc(1'b0, 1'b0, 1'b1, 32'h400);
        chk("brC_hold_addr", addr, 32'h104);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("brC_last_wins", addr, 32'h400);
        chk("brC_valid", {31'h0, valid}, 32'h0);

        // branch while frozen with the skid buffer full
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("skid_pre_pc", pc, 32'h404);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("skid_hold_req", {31'h0, req}, 32'h0);
        chk("skid_hold_addr", addr, 32'h408);
        chk("skid_hold_valid", {31'h0, valid}, 32'h1);
        chk("skid_hold_pc", pc, 32'h404);
        cyc(1'b0, 1'b1, 1'b1, 32'h200);
        chk("skid_br_valid", {31'h0, valid}, 32'h0);
        chk("skid_br_addr", addr, 32'h200);
        chk("skid_br_req", {31'h0, req}, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("skid_br_pc", pc, 32'h204);
        chk("skid_br_instr", instr, 32'h200 ^ KEY);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("skid_dropped", {31'h0, valid}, 32'h0);

        // address wrap
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("wrap_addr", addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_instr", instr, 32'h5A5A_FFFC);
        chk("wrap_next_addr", addr, 32'h0);

        // reset mid-request with branch and freeze asserted, then a stray ack in idle
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_pre_addr", addr, 32'h4);
        rst_n = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 32'h500);
        chk("rst_mid_req", {31'h0, req}, 32'h0);
        chk("rst_mid_addr", addr, 32'h0);
        chk("rst_mid_valid", {31'h0, valid}, 32'h0);
        chk("rst_mid_pc", pc, 32'h0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("idle_ack_req", {31'h0, req}, 32'h1);
        chk("idle_ack_addr", addr, 32'h0);
        chk("idle_ack_valid", {31'h0, valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
